// File: rtl/stm_frame_collector.sv
// Frame collector behind the STM output stage. Each START begins a DEPTH-sample frame.
// Samples fill the inactive bank of a ping-pong buffer, and the banks swap atomically when the frame completes.
module stm_frame_collector #(
    parameter int DEPTH = 249,
    parameter int IDX_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [IDX_W-1:0] IDX_IN,
    input  logic             DIN_VALID,
    input  logic [7:0]       DIN_INTENSITY,
    input  logic [7:0]       DIN_PHASE,
    input  logic [7:0]       RD_ADDR,
    output logic [7:0]       RD_INTENSITY,
    output logic [7:0]       RD_PHASE,
    output logic             FRAME_READY,
    output logic             FRAME_UPDATE,
    output logic [IDX_W-1:0] FRAME_IDX,
    input  logic             ERR_CLR,
    output logic             ERR_OVERFLOW,
    output logic [7:0]       ABORT_COUNT,
    output logic [1:0]       DBG_STATE
);
    localparam int CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [8:0]       DEPTH_9  = 9'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_d;
    logic [IDX_W-1:0] pending_idx, pending_idx_d;
    logic             active_bank;
    logic             wr_en, frame_done, abort, overflow;
    logic [15:0]      rd_q;

    logic [15:0] mem0 [0:DEPTH-1];
    logic [15:0] mem1 [0:DEPTH-1];

    // START overrides everything, including a sample arriving in the same cycle.
    always_comb begin
        state_d       = state;
        wr_cnt_d      = wr_cnt;
        pending_idx_d = pending_idx;
        wr_en         = 1'b0;
        frame_done    = 1'b0;
        abort         = 1'b0;
        overflow      = 1'b0;
        if (START) begin
            state_d       = S_FILL;
            wr_cnt_d      = '0;
            pending_idx_d = IDX_IN;
            abort         = (state == S_FILL);
        end else if (DIN_VALID) begin
            if (state == S_FILL) begin
                wr_en = 1'b1;
                if (wr_cnt == LAST_CNT) begin
                    wr_cnt_d   = '0;
                    frame_done = 1'b1;
                    state_d    = S_DONE;
                end else begin
                    wr_cnt_d = wr_cnt + 1'b1;
                end
            end else begin
                overflow = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            wr_cnt       <= '0;
            pending_idx  <= '0;
            active_bank  <= 1'b0;
            FRAME_READY  <= 1'b0;
            FRAME_UPDATE <= 1'b0;
            FRAME_IDX    <= '0;
            ERR_OVERFLOW <= 1'b0;
            ABORT_COUNT  <= '0;
        end else begin
            state        <= state_d;
            wr_cnt       <= wr_cnt_d;
            pending_idx  <= pending_idx_d;
            FRAME_UPDATE <= frame_done;
            if (frame_done) begin
                active_bank <= ~active_bank;
                FRAME_IDX   <= pending_idx;
                FRAME_READY <= 1'b1;
            end
            if (overflow)
                ERR_OVERFLOW <= 1'b1;
            else if (ERR_CLR)
                ERR_OVERFLOW <= 1'b0;
            if (abort && ABORT_COUNT != 8'hFF)
                ABORT_COUNT <= ABORT_COUNT + 8'd1;
        end
    end

    // Buffer RAM: writes always land in the bank the reader is not using.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            if (active_bank)
                mem0[wr_cnt] <= {DIN_INTENSITY, DIN_PHASE};
            else
                mem1[wr_cnt] <= {DIN_INTENSITY, DIN_PHASE};
        end
    end

    // The bank swap and the last write share an edge, so the read after a swap sees a whole frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            rd_q <= '0;
        else if (FRAME_READY && ({1'b0, RD_ADDR} < DEPTH_9))
            rd_q <= active_bank ? mem1[RD_ADDR] : mem0[RD_ADDR];
        else
            rd_q <= '0;
    end

    assign RD_INTENSITY = rd_q[15:8];
    assign RD_PHASE     = rd_q[7:0];
    assign DBG_STATE    = state;
endmodule

// File: tb/tb_stm_frame_collector.sv
// Directed bench for stm_frame_collector.
// It uses a read-address vector table plus hand-written multi-cycle sequences for swap, abort, overflow and reset corners.
module tb_stm_frame_collector;
    localparam int DEPTH = 249;
    localparam int IDX_W = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [IDX_W-1:0] IDX_IN = '0;
    logic             DIN_VALID = 1'b0;
    logic [7:0]       DIN_INTENSITY = '0;
    logic [7:0]       DIN_PHASE = '0;
    logic [7:0]       RD_ADDR = '0;
    logic [7:0]       RD_INTENSITY, RD_PHASE;
    logic             FRAME_READY, FRAME_UPDATE;
    logic [IDX_W-1:0] FRAME_IDX;
    logic             ERR_CLR = 1'b0;
    logic             ERR_OVERFLOW;
    logic [7:0]       ABORT_COUNT;
    logic [1:0]       DBG_STATE;

    stm_frame_collector #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .IDX_IN(IDX_IN),
        .DIN_VALID(DIN_VALID), .DIN_INTENSITY(DIN_INTENSITY), .DIN_PHASE(DIN_PHASE),
        .RD_ADDR(RD_ADDR), .RD_INTENSITY(RD_INTENSITY), .RD_PHASE(RD_PHASE),
        .FRAME_READY(FRAME_READY), .FRAME_UPDATE(FRAME_UPDATE), .FRAME_IDX(FRAME_IDX),
        .ERR_CLR(ERR_CLR), .ERR_OVERFLOW(ERR_OVERFLOW), .ABORT_COUNT(ABORT_COUNT),
        .DBG_STATE(DBG_STATE)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;
    int upd_seen = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp_i;
        logic [7:0] exp_p;
    } rd_vec_t;
    rd_vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame(input logic [IDX_W-1:0] idx);
        START = 1'b1;
        IDX_IN = idx;
        tick();
        START = 1'b0;
    endtask

    task automatic fill(input logic [7:0] seed, input int n);
        for (int a = 0; a < n; a++) begin
            DIN_VALID = 1'b1;
            DIN_INTENSITY = 8'(a + seed);
            DIN_PHASE = 8'(255 - a);
            tick();
            if (FRAME_UPDATE) upd_seen++;
        end
        DIN_VALID = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " frame_ready"}, FRAME_READY, 0);
        chk({tag, " frame_update"}, FRAME_UPDATE, 0);
        chk({tag, " frame_idx"}, FRAME_IDX, 0);
        chk({tag, " rd_int"}, RD_INTENSITY, 0);
        chk({tag, " rd_ph"}, RD_PHASE, 0);
        chk({tag, " err_ovf"}, ERR_OVERFLOW, 0);
        chk({tag, " abort_cnt"}, ABORT_COUNT, 0);
        chk({tag, " state"}, DBG_STATE, 0);
    endtask

    initial begin
        vecs[0] = '{8'd0,   8'd0,   8'd255};
        vecs[1] = '{8'd10,  8'd10,  8'd245};
        vecs[2] = '{8'd100, 8'd100, 8'd155};
        vecs[3] = '{8'd248, 8'd248, 8'd7};
        vecs[4] = '{8'd249, 8'd0,   8'd0};
        vecs[5] = '{8'd255, 8'd0,   8'd0};

        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        RST = 1'b0;
        tick();

        // First frame, IDX 5, intensity=addr, phase=255-addr
        start_frame(16'd5);
        chk("s1 state fill", DBG_STATE, 1);
        chk("s1 ready before", FRAME_READY, 0);
        upd_seen = 0;
        fill(8'd0, DEPTH);
        chk("s1 update pulse", FRAME_UPDATE, 1);
        chk("s1 update count", upd_seen, 1);
        chk("s1 frame_idx", FRAME_IDX, 5);
        chk("s1 frame_ready", FRAME_READY, 1);
        chk("s1 state done", DBG_STATE, 2);
        tick();
        chk("s1 update one cycle", FRAME_UPDATE, 0);
        chk("s1 no overflow", ERR_OVERFLOW, 0);

        for (int i = 0; i < 6; i++) begin
            RD_ADDR = vecs[i].addr;
            tick();
            chk($sformatf("tbl rd_int addr %0d", vecs[i].addr), RD_INTENSITY, vecs[i].exp_i);
            chk($sformatf("tbl rd_ph addr %0d", vecs[i].addr), RD_PHASE, vecs[i].exp_p);
        end

        // Ping-pong: A (IDX 1, seed 0x10) stays visible until B (IDX 2, seed 0x40) swaps in
        start_frame(16'd1);
        fill(8'h10, DEPTH);
        RD_ADDR = 8'd0;
        tick();
        tick();
        chk("pp A visible", RD_INTENSITY, 8'h10);
        start_frame(16'd2);
        chk("pp A after start", RD_INTENSITY, 8'h10);
        for (int a = 0; a < DEPTH; a++) begin
            DIN_VALID = 1'b1;
            DIN_INTENSITY = 8'(a + 8'h40);
            DIN_PHASE = 8'(255 - a);
            tick();
            if (a < DEPTH - 1) chk($sformatf("pp A during fill %0d", a), RD_INTENSITY, 8'h10);
        end
        DIN_VALID = 1'b0;
        chk("pp update cycle", FRAME_UPDATE, 1);
        chk("pp old data in update cycle", RD_INTENSITY, 8'h10);
        tick();
        chk("pp B int", RD_INTENSITY, 8'h40);
        chk("pp B ph", RD_PHASE, 8'hFF);
        chk("pp B idx", FRAME_IDX, 2);

        // Abort: 100 samples, restart with IDX 9, full frame
        upd_seen = 0;
        start_frame(16'd7);
        fill(8'h20, 100);
        start_frame(16'd9);
        chk("abort count 1", ABORT_COUNT, 1);
        chk("abort idx kept", FRAME_IDX, 2);
        fill(8'h30, DEPTH);
        chk("abort single update", upd_seen, 1);
        chk("abort frame_idx", FRAME_IDX, 9);
        RD_ADDR = 8'd150;
        tick();
        tick();
        chk("abort rd_int 150", RD_INTENSITY, 8'hC6);
        chk("abort rd_ph 150", RD_PHASE, 8'h69);

        // Overflow in DONE, then ERR_CLR behaviour
        DIN_VALID = 1'b1;
        DIN_INTENSITY = 8'hEE;
        DIN_PHASE = 8'hEE;
        RD_ADDR = 8'd0;
        tick();
        DIN_VALID = 1'b0;
        chk("ovf set", ERR_OVERFLOW, 1);
        chk("ovf no swap", FRAME_UPDATE, 0);
        chk("ovf state done", DBG_STATE, 2);
        tick();
        chk("ovf no write int", RD_INTENSITY, 8'h30);
        chk("ovf idx kept", FRAME_IDX, 9);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        chk("ovf cleared", ERR_OVERFLOW, 0);
        DIN_VALID = 1'b1;
        tick();
        chk("ovf set again", ERR_OVERFLOW, 1);
        ERR_CLR = 1'b1;
        tick();
        chk("ovf wins over clr", ERR_OVERFLOW, 1);
        DIN_VALID = 1'b0;
        tick();
        ERR_CLR = 1'b0;
        chk("ovf cleared again", ERR_OVERFLOW, 0);

        // START coincident with the last sample: no swap, abort counted
        upd_seen = 0;
        start_frame(16'd11);
        fill(8'h50, DEPTH - 1);
        START = 1'b1;
        IDX_IN = 16'd12;
        DIN_VALID = 1'b1;
        DIN_INTENSITY = 8'(248 + 8'h50);
        DIN_PHASE = 8'd7;
        RD_ADDR = 8'd248;
        tick();
        START = 1'b0;
        DIN_VALID = 1'b0;
        chk("last-start no update", FRAME_UPDATE, 0);
        chk("last-start no update seen", upd_seen, 0);
        chk("last-start abort 2", ABORT_COUNT, 2);
        chk("last-start idx kept", FRAME_IDX, 9);
        chk("last-start state fill", DBG_STATE, 1);
        tick();
        chk("last-start active int 248", RD_INTENSITY, 8'h28);
        chk("last-start active ph 248", RD_PHASE, 8'd7);

        // Consecutive aborts saturate at 255
        for (int k = 1; k <= 256; k++) begin
            START = 1'b1;
            IDX_IN = 16'(k);
            tick();
            if (k == 252) chk("abort count 254", ABORT_COUNT, 254);
        end
        START = 1'b0;
        chk("abort saturated", ABORT_COUNT, 255);

        // Async reset mid-FILL after 50 samples
        fill(8'h00, 50);
        RD_ADDR = 8'd0;
        RST = 1'b1;
        #1;
        chk_all_zero("midfill rst");
        tick();
        RST = 1'b0;
        tick();
        chk("post-rst rd_int addr 0", RD_INTENSITY, 0);
        chk("post-rst rd_ph addr 0", RD_PHASE, 0);
        RD_ADDR = 8'd250;
        tick();
        chk("post-rst rd_int addr 250", RD_INTENSITY, 0);
        chk("post-rst rd_ph addr 250", RD_PHASE, 0);
        chk("post-rst state idle", DBG_STATE, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/stm_frame_collector.md
Name: stm_frame_collector

Overview:
- Sits directly downstream of the STM output stage.
- Captures the per-transducer INTENSITY/PHASE stream, qualified by DOUT_VALID, that follows each START pulse.
- Assembles DEPTH samples into a ping-pong buffer and swaps banks atomically once a frame is complete.
- The PWM/drive stage reads a stable, complete frame by transducer address while the next frame fills.

Parameters:
DEPTH, 249, transducers per frame (samples per START)
IDX_W, 16, width of the frame index tag

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-high reset
START  in  1  frame-start pulse, same pulse that launches the upstream stage
IDX_IN  in  IDX_W  STM index of the frame being launched, sampled on START
DIN_VALID  in  1  upstream DOUT_VALID
DIN_INTENSITY  in  8  upstream INTENSITY
DIN_PHASE  in  8  upstream PHASE
RD_ADDR  in  8  transducer address to read, 0..DEPTH-1
RD_INTENSITY  out  8  intensity at RD_ADDR from the active bank
RD_PHASE  out  8  phase at RD_ADDR from the active bank
FRAME_READY  out  1  high once at least one frame has completed
FRAME_UPDATE  out  1  one-cycle pulse on bank swap
FRAME_IDX  out  IDX_W  IDX_IN tag of the frame in the active bank
ERR_CLR  in  1  clears ERR_OVERFLOW
ERR_OVERFLOW  out  1  sticky: a valid sample arrived outside FILL
ABORT_COUNT  out  8  saturating count of frames aborted by an early START

Behaviour:
- Clock/reset: single clock CLK; RST is asynchronous, active-high.
- Reset values:
  - state IDLE, wr_cnt=0, active bank 0.
  - All outputs 0: FRAME_READY, FRAME_UPDATE, FRAME_IDX, RD_INTENSITY, RD_PHASE, ERR_OVERFLOW, ABORT_COUNT.
  - Buffer RAM is not reset.
- States:
  - IDLE: no frame ever started.
  - FILL: capturing into the inactive bank.
  - DONE: frame complete, waiting for the next START.
- START in any state:
  - next state FILL, wr_cnt<=0, pending_idx<=IDX_IN.
  - START has priority; a DIN_VALID sample in the same cycle is dropped.
- START while in FILL:
  - partial frame discarded, ABORT_COUNT+1, saturating at 255.
  - The active bank is untouched.
- In FILL with DIN_VALID=1 and no START:
  - write {intensity, phase} to the inactive bank at wr_cnt, then wr_cnt+1.
- Frame completion:
  - The write of sample DEPTH-1 in cycle t completes the frame.
  - Cycle t+1: active bank toggles, FRAME_UPDATE=1 for exactly one cycle, FRAME_IDX<=pending_idx, FRAME_READY<=1, state DONE.
  - A START in cycle t drops that last sample and counts as an abort; no swap occurs.
- DIN_VALID=1 in IDLE or DONE: sample ignored, ERR_OVERFLOW<=1.
- ERR_CLR:
  - ERR_OVERFLOW<=0.
  - A new overflow in the same cycle wins (ERR_OVERFLOW stays 1).
- Read path:
  - RD_ADDR registered; 1-cycle latency (data for an address presented in cycle n is valid in n+1).
  - Reads target the bank that is active in cycle n.
  - Reads issued in the FRAME_UPDATE cycle or later see the new frame; no torn frame is ever visible.
  - RD_ADDR>=DEPTH returns 0/0.
  - While FRAME_READY=0, RD outputs are forced to 0.
- wr_cnt width: ceil(log2(DEPTH)); it never exceeds DEPTH-1.
- RST mid-FILL: partial frame lost, all state returns to reset values immediately.

Test Plan:
- Reset, START with IDX_IN=5, then 249 valid samples (intensity=addr, phase=255-addr) -> FRAME_UPDATE one cycle after the last sample; FRAME_IDX=5, FRAME_READY=1; RD_ADDR=10 returns 10/245 one cycle later.
- Frame A (IDX 1) complete; frame B (IDX 2) filling while reading addr 0 every cycle -> reads return A until the FRAME_UPDATE cycle, then B.
- START, 100 samples, START again with IDX_IN=9, then 249 samples -> ABORT_COUNT=1, single FRAME_UPDATE, FRAME_IDX=9.
- After DONE, one extra DIN_VALID -> ERR_OVERFLOW=1, no write or swap; ERR_CLR alone clears it; ERR_CLR together with a new valid keeps it at 1.
- START coincident with sample 248 -> no swap, ABORT_COUNT increments; 256 consecutive aborts -> ABORT_COUNT saturates at 255.
- RST asserted mid-FILL at sample 50 -> outputs 0 immediately; RD_ADDR=0 and RD_ADDR=250 both return 0.
